aes_state_loader: RTL

Input stage of the AES datapath. It collects four 32-bit bus words into one 128-bit AES state, optionally XORs in the initial round key (round-0 AddRoundKey), and presents the result to the SubBytes round path over a valid/ready handshake. A fill buffer plus an output register let the next block load while the current one waits, so a continuous stream sustains one state every 4 cycles.

---
 rtl/aes_pkg.sv | 9 +
 rtl/aes_state_loader.sv | 52 +++++
 2 files changed

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath widths and column-major byte indexing
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_NB      = 4;
  function automatic int byte_idx(input int r, input int c);
    return AES_NB * c + r;
  endfunction
endpackage

// File: rtl/aes_state_loader.sv
// aes_state_loader: packs four bus words into an AES state with optional round-0 key XOR
module aes_state_loader
  import aes_pkg::*;
#(
  parameter bit KEY_XOR = 1'b1
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic                   iClear,
  input  logic                   iWordValid,
  input  logic [AES_WORD_W-1:0]  iWord,
  output logic                   oWordReady,
  input  logic [AES_STATE_W-1:0] iKey,
  output logic                   oStateValid,
  output logic [AES_STATE_W-1:0] oState,
  input  logic                   iStateReady,
  output logic [1:0]             oWordCnt
);
  logic [1:0]             cnt;
  logic [AES_STATE_W-1:0] fill;
  logic [AES_STATE_W-1:0] assembled;
  logic                   accept, xfer, take;
  assign oWordCnt   = cnt;
  assign oWordReady = (cnt != 2'd3) | ~oStateValid | iStateReady;
  assign accept     = iWordValid & oWordReady;
  assign xfer       = accept & (cnt == 2'd3);
  assign take       = oStateValid & iStateReady;
  // the last column bypasses the fill buffer so the state moves on the accepting edge
  assign assembled  = {iWord, fill[AES_STATE_W-AES_WORD_W-1:0]} ^ (KEY_XOR ? iKey : '0);
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      cnt         <= '0;
      fill        <= '0;
      oStateValid <= 1'b0;
      oState      <= '0;
    end else if (iClear) begin
      cnt         <= '0;
      oStateValid <= 1'b0;
    end else begin
      if (accept) begin
        fill[AES_WORD_W*cnt +: AES_WORD_W] <= iWord;
        cnt <= cnt + 2'd1;
      end
      if (xfer) begin
        oState      <= assembled;
        oStateValid <= 1'b1;
      end else if (take) begin
        oStateValid <= 1'b0;
      end
    end
  end
endmodule
